chunked_serial_adder: RTL and testbench

- Parametrised multi-cycle successor to the single-bit full adder. Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through an internal carry register.
- Adds a subtract mode and a signed-overflow flag.
- Uses valid/ready handshakes on both the input and result sides, so it drops into streaming datapaths where area matters more than latency.

---
 rtl/chunked_serial_adder.sv | 155 +++++++++++++++
 tb/tb_chunked_serial_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per
// clock, least-significant chunk first. A carry register links one chunk to the
// next. Operands come in and results go out through valid/ready handshakes, so
// the block fits streaming datapaths that trade latency for a narrow adder.
//
// Parameters
//   WIDTH : operand/result width (>= 1)
//   CHUNK : bits added per cycle (1..WIDTH, WIDTH % CHUNK == 0)
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operands valid
//   in_ready  : block idle and able to accept operands
//   A, B      : operands
//   Ci        : carry in (ignored when Sub=1)
//   Sub       : 0 -> S = A + B + Ci, 1 -> S = A - B
//   out_valid : result valid, held until out_ready
//   out_ready : consumer accepts result
//   S         : sum / difference
//   Co        : carry out (in subtract mode 1 = no borrow)
//   V         : two's-complement signed overflow
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_serial_adder: invalid WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  // The final V decision needs the operand sign bits, but those bits leave
  // the shift registers during the run. They are captured at accept.
  logic             msb_a;
  logic             msb_b;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;
  logic             last_chunk;

  // Signed overflow: the operands have the same sign, but the result's sign differs.
  function automatic logic signed_ovf(input logic ma, input logic mb, input logic ms);
    return (ma == mb) && (ms != ma);
  endfunction

  assign chunk_sum  = {1'b0, a_sr[CHUNK-1:0]} + {1'b0, b_sr[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign last_chunk = (cnt == CW'(N - 1));

  // Each new chunk enters at the top of the result register and moves down.
  // After N cycles the first chunk sits in the least-significant position.
  if (CHUNK == WIDTH) begin : g_single
    assign res_next = chunk_sum[CHUNK-1:0];
  end else begin : g_multi
    assign res_next = {chunk_sum[CHUNK-1:0], res_sr[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      msb_a     <= 1'b0;
      msb_b     <= 1'b0;
      S         <= '0;
      Co        <= 1'b0;
      V         <= 1'b0;
    end else begin
      case (state)
        // accept: subtraction is A + ~B + 1
        IDLE: begin
          if (in_valid) begin
            a_sr     <= A;
            b_sr     <= Sub ? ~B : B;
            carry    <= Sub ? 1'b1 : Ci;
            msb_a    <= A[WIDTH-1];
            msb_b    <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end

        // one chunk per cycle
        RUN: begin
          res_sr <= res_next;
          carry  <= chunk_sum[CHUNK];
          a_sr   <= a_sr >> CHUNK;
          b_sr   <= b_sr >> CHUNK;
          cnt    <= cnt + 1'b1;
          if (last_chunk) begin
            state     <= DONE;
            out_valid <= 1'b1;
            S         <= res_next;
            Co        <= chunk_sum[CHUNK];
            V         <= signed_ovf(msb_a, msb_b, res_next[WIDTH-1]);
          end
        end

        // hold result until consumed
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_serial_adder
//
// Testbench for chunked_serial_adder. It runs directed cases on an 8-bit/2-bit
// instance: overflow, subtract, back-pressure and asynchronous reset. It then
// runs an exhaustive sweep on 4-bit instances with CHUNK = 1, 2 and 4.
// A scoreboard queue holds the expected results. Each expected value is
// computed from unsigned and signed arithmetic at the moment the stimulus is
// driven.
// -----------------------------------------------------------------------------
module tb_chunked_serial_adder;

  typedef struct {
    int s;
    int co;
    int v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bit, CHUNK=2 instance
  logic       iv8, ir8, ov8, ordy8, ci8, sub8, co8, v8;
  logic [7:0] a8, b8, s8;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Ci(ci8), .Sub(sub8),
    .out_valid(ov8), .out_ready(ordy8),
    .S(s8), .Co(co8), .V(v8)
  );

  // 4-bit instances sharing one stimulus
  logic       iv4, ci4, sub4, ordy4;
  logic [3:0] a4, b4;
  logic [2:0] ir4, ov4, co4, v4;
  logic [3:0] s4 [3];

  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) dut4_c1 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[0]),
    .A(a4), .B(b4), .Ci(ci4), .Sub(sub4),
    .out_valid(ov4[0]), .out_ready(ordy4), .S(s4[0]), .Co(co4[0]), .V(v4[0])
  );
  chunked_serial_adder #(.WIDTH(4), .CHUNK(2)) dut4_c2 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[1]),
    .A(a4), .B(b4), .Ci(ci4), .Sub(sub4),
    .out_valid(ov4[1]), .out_ready(ordy4), .S(s4[1]), .Co(co4[1]), .V(v4[1])
  );
  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut4_c4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[2]),
    .A(a4), .B(b4), .Ci(ci4), .Sub(sub4),
    .out_valid(ov4[2]), .out_ready(ordy4), .S(s4[2]), .Co(co4[2]), .V(v4[2])
  );

  exp_t sb8[$];
  exp_t sb4_0[$];
  exp_t sb4_1[$];
  exp_t sb4_2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: unsigned arithmetic gives S/Co, signed range gives V
  function automatic exp_t model(input int w, input int a, input int b, input int ci, input int sub);
    exp_t e;
    int   m, sa, sb, u, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub == 0) begin
      u    = a + b + ci;
      e.co = (u >= m) ? 1 : 0;
      e.s  = u % m;
      sr   = sa + sb + ci;
    end else begin
      e.co = (a >= b) ? 1 : 0;
      e.s  = (a - b + m) % m;
      sr   = sa - sb;
    end
    e.v = (sr > m / 2 - 1 || sr < -(m / 2)) ? 1 : 0;
    return e;
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; sub8 = sub; iv8 = 1'b1;
    check("in_ready_idle", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    e = model(8, int'(a), int'(b), int'(ci), int'(sub));
    sb8.push_back(e);
    check("in_ready_busy", 32'(ir8), 32'd0);
  endtask

  task automatic wait8(input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (!ov8 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd4);
    if (sb8.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb8.pop_front();
      check({tag, "_S"}, 32'(s8), 32'(e.s));
      check({tag, "_Co"}, 32'(co8), 32'(e.co));
      check({tag, "_V"}, 32'(v8), 32'(e.v));
    end
  endtask

  task automatic exit8(input string tag);
    @(posedge clk); #1;
    check({tag, "_out_valid_drop"}, 32'(ov8), 32'd0);
    check({tag, "_in_ready_back"}, 32'(ir8), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_s;
    logic       hold_co, hold_v;
    exp_t       e;
    int         lat [3];
    int         nexp [3];

    nexp[0] = 4; nexp[1] = 2; nexp[2] = 1;
    iv8 = 0; ordy8 = 1; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0;
    iv4 = 0; ordy4 = 1; a4 = 0; b4 = 0; ci4 = 0; sub4 = 0;

    // reset state
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_S", 32'(s8), 32'd0);
    check("rst_Co_V", 32'({co8, v8}), 32'd0);
    check("rst_w4_ready", 32'(ir4), 32'd7);
    check("rst_w4_valid", 32'(ov4), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // carry out of the top chunk
    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait8("ff_plus_1");
    exit8("ff_plus_1");

    // signed overflow, then carry-in
    start8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8("7f_plus_1");
    exit8("7f_plus_1");
    start8(8'h3C, 8'h0F, 1'b1, 1'b0);
    wait8("3c_plus_f_ci");
    exit8("3c_plus_f_ci");

    // subtract, Ci ignored
    start8(8'h05, 8'h07, 1'b1, 1'b1);
    wait8("5_minus_7");
    exit8("5_minus_7");
    start8(8'h80, 8'h01, 1'b0, 1'b1);
    wait8("80_minus_1");
    exit8("80_minus_1");

    // back-pressure with in_valid held and operands changing
    ordy8 = 1'b0;
    start8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8("bp");
    hold_s = s8; hold_co = co8; hold_v = v8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); iv8 = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(ov8), 32'd1);
      check("bp_S_stable", 32'(s8), 32'(hold_s));
      check("bp_Co_V_stable", 32'({co8, v8}), 32'({hold_co, hold_v}));
      check("bp_in_ready", 32'(ir8), 32'd0);
    end
    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(ov8), 32'd0);
    check("bp_release_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept_on_exit", 32'(ir8), 32'd1);
    check("bp_S_kept", 32'(s8), 32'(hold_s));

    // asynchronous reset in the middle of RUN
    start8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(ov8), 32'd0);
    check("arst_S", 32'(s8), 32'd0);
    check("arst_Co_V", 32'({co8, v8}), 32'd0);
    check("arst_in_ready", 32'(ir8), 32'd1);
    sb8.delete();
    @(negedge clk);
    rst = 1'b0;
    start8(8'h10, 8'h20, 1'b0, 1'b0);
    wait8("after_rst");
    exit8("after_rst");

    // exhaustive 4-bit sweep on CHUNK = 1, 2, 4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          for (int sub = 0; sub < 2; sub++) begin
            @(negedge clk);
            a4 = 4'(a); b4 = 4'(b); ci4 = 1'(ci); sub4 = 1'(sub); iv4 = 1'b1;
            check("w4_in_ready", 32'(ir4), 32'd7);
            @(posedge clk); #1;
            iv4 = 1'b0;
            e = model(4, a, b, ci, sub);
            sb4_0.push_back(e); sb4_1.push_back(e); sb4_2.push_back(e);
            for (int j = 0; j < 3; j++) lat[j] = -1;
            for (int k = 1; k <= 7; k++) begin
              @(posedge clk); #1;
              for (int j = 0; j < 3; j++) begin
                if (ov4[j] && lat[j] < 0) begin
                  lat[j] = k;
                  if (j == 0) e = sb4_0.pop_front();
                  else if (j == 1) e = sb4_1.pop_front();
                  else e = sb4_2.pop_front();
                  check($sformatf("w4c%0d_S a=%0d b=%0d ci=%0d sub=%0d", j, a, b, ci, sub), 32'(s4[j]), 32'(e.s));
                  check($sformatf("w4c%0d_Co a=%0d b=%0d ci=%0d sub=%0d", j, a, b, ci, sub), 32'(co4[j]), 32'(e.co));
                  check($sformatf("w4c%0d_V a=%0d b=%0d ci=%0d sub=%0d", j, a, b, ci, sub), 32'(v4[j]), 32'(e.v));
                end
              end
            end
            for (int j = 0; j < 3; j++)
              check($sformatf("w4c%0d_latency", j), 32'(lat[j]), 32'(nexp[j]));
            sb4_0.delete(); sb4_1.delete(); sb4_2.delete();
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
